// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit: radix-2 shift-add multiply and
// restoring shift-subtract divide, one operation in flight, start/busy/done handshake.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [REG_AW-1:0] rd_out,
  output logic              we_out
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic [REG_AW-1:0]   rdo_q, rdo_d;

  logic [XLEN:0]       msum;
  logic [XLEN+1:0]     shl, diff;
  logic                ge;

  always_comb begin
    msum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
    shl  = {rem_q, quo_q[XLEN-1]};
    diff = shl - {2'b00, b_q};
    // shl < 2*b always, so the top bit of diff is a clean borrow flag
    ge   = ~diff[XLEN+1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    rd_d    = rd_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    rdo_d   = rdo_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d = RUN;
          op_d    = op;
          b_d     = src_b;
          rd_d    = rd_in;
          cnt_d   = '0;
          prod_d  = {{XLEN{1'b0}}, src_a};
          rem_d   = '0;
          quo_d   = src_a;
          if (op[1] && (src_b == '0)) begin
            // divide by zero: preload the architectural answer and skip the iterations
            cnt_d = CW'(XLEN);
            quo_d = '1;
            rem_d = {1'b0, src_a};
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(XLEN)) begin
          state_d = DONE;
          rdo_d   = rd_q;
          case (op_q)
            2'b00:   res_d = prod_q[XLEN-1:0];
            2'b01:   res_d = prod_q[2*XLEN-1:XLEN];
            2'b10:   res_d = quo_q;
            default: res_d = rem_q[XLEN-1:0];
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (op_q[1]) begin
            rem_d = ge ? diff[XLEN:0] : shl[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], ge};
          end else begin
            prod_d = {msum, prod_q[XLEN-1:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      rdo_q   <= rdo_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign we_out = done && (rdo_q != '0);
  assign result = res_q;
  assign rd_out = rdo_q;
endmodule
